matmul_feeder: RTL and testbench
================================

Name: matmul_feeder

Overview:
- Transmit side of the systolic-array operand interface.
- Latches full operand matrices A (N×K) and B (K×M) on a start handshake.
- Streams them cycle by cycle into the array's per-row A port and per-column B port, with diagonal skew and zero padding.
- Owns the array enable, and signals completion once the final PE has accumulated its last product.

Parameters:
- DW, 8, operand element width in bits
- BW, 32, array accumulator width; sets MAX_DIM
- MAX_DIM, BW/DW, maximum rows/cols of any matrix
- PE_LAT, 1, cycles from operand presented at a PE until its accumulator reflects the product

Ports:
- clk_i  in  1  clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- start_i  in  1  request to run one multiplication; sampled only in IDLE
- dim_n_i  in  $clog2(MAX_DIM)  N-1 (rows of A)
- dim_k_i  in  $clog2(MAX_DIM)  K-1 (inner dimension)
- dim_m_i  in  $clog2(MAX_DIM)  M-1 (cols of B)
- mat_a_i  in  MAX_DIM*MAX_DIM*DW  A element (r,k) at bits [(r*MAX_DIM+k)*DW +: DW]
- mat_b_i  in  MAX_DIM*MAX_DIM*DW  B element (k,c) at bits [(k*MAX_DIM+c)*DW +: DW]
- in_a_o  out  MAX_DIM*DW  row r operand at [r*DW +: DW], to array A port
- in_b_o  out  MAX_DIM*DW  column c operand at [c*DW +: DW], to array B port
- array_start_o  out  1  array enable; PEs accumulate while high, clear while low
- busy_o  out  1  high in FEED, DRAIN and DONE
- done_o  out  1  one-cycle pulse; array result valid this cycle

Behaviour:
- All outputs are registered.
- Reset (async assert, any state): state=IDLE, counter=0, latched matrices=0, all outputs 0.
- States and transitions:
  - IDLE: outputs 0. start_i=1 → latch A, B, N, K, M; clear t; go to FEED on the next edge.
  - FEED: t runs from 0 to T_F-1, where T_F = N+K+M-2. Then go to DRAIN.
  - DRAIN: PE_LAT cycles. Operands are 0; array_start_o stays 1. Then go to DONE.
  - DONE: done_o=1 and array_start_o=1 for exactly one cycle, then IDLE.
- Skew rule, at FEED cycle t:
  - in_a_o row r = A[r][t-r] if r<N and 0≤t-r<K, else 0.
  - in_b_o col c = B[t-c][c] if c<M and 0≤t-c<K, else 0.
- array_start_o rises with the first FEED cycle and falls on the cycle after DONE.
- Latency: start_i accepted at cycle 0; done_o at cycle 1+T_F+PE_LAT.
- Boundary conditions:
  - start_i in FEED, DRAIN or DONE: ignored; no restart, no queuing.
  - mat_*_i and dim_*_i changes after accept: no effect on the current run.
  - N=K=M=1: T_F=1. Single FEED cycle drives A[0][0] and B[0][0].
  - Rows ≥N and cols ≥M: driven to 0 for the whole run, so unused PEs accumulate 0.
  - reset_i mid-run: immediate abort; next start_i after release begins a clean run.
  - Counter width is $clog2(3*MAX_DIM+PE_LAT) and never wraps.

Decomposition:
- Shared package:
  - state enum (IDLE, FEED, DRAIN, DONE)
  - MAX_DIM derivation
  - element-slice index helper function, shared with the array and result readback logic
- One natural sub-module, matmul_skew_lane: one instance per row/column. It selects element (t-idx) from a latched vector, gated by idx<limit and the 0..K-1 window.

Test Plan:
- Reset mid-FEED (reset_i pulsed at t=2 of a 4×4×4 run) → all outputs 0 same cycle; no done_o. Fresh start_i afterwards completes normally.
- 2×2×2, A=[[1,2],[3,4]], B=[[5,6],[7,8]] → per FEED cycle, row0/row1 and col0/col1:
  - t0: row 1/0, col 5/0
  - t1: row 2/3, col 7/6
  - t2: row 0/4, col 0/8
  - t3: all 0
  - done_o at cycle 6.
  - Integrated with the array and in_c=0 → result [[19,22],[43,50]].
- 1×1×1, A=9, B=3 → single FEED cycle showing 9/3; done_o at cycle 3; array result 27.
- 4×4×4 with A=identity, B=k*4+c+1 → 10 FEED cycles; done_o at cycle 12; result equals B.
- start_i held high through an entire 3×2×3 run → exactly one done_o per run.
  - Second run starts the cycle after return to IDLE.
  - mat_a_i changed during FEED does not alter the emitted stream.
- N=2, K=3, M=1 → in_a_o rows 2-3 and in_b_o cols 1-3 remain 0 every cycle; busy_o high for exactly 6 cycles.

Source files
------------

// File: rtl/matmul_feeder_pkg.sv
// Shared types and sizing for the systolic-array operand feeder.
// Matrix elements are flattened row-major into MAX_DIM x MAX_DIM slots.
package matmul_feeder_pkg;
  localparam int DW      = 8;
  localparam int BW      = 32;
  localparam int MAX_DIM = BW / DW;
  localparam int PE_LAT  = 1;
  localparam int DIM_W   = $clog2(MAX_DIM);
  localparam int CNT_W   = $clog2(3 * MAX_DIM + PE_LAT);
  localparam int VEC_W   = MAX_DIM * DW;
  localparam int MAT_W   = MAX_DIM * MAX_DIM * DW;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_e;

  // Flat slot of element (row, col) in any MAX_DIM x MAX_DIM matrix bus.
  function automatic int elem_idx(input int row, input int col);
    return row * MAX_DIM + col;
  endfunction
endpackage

// File: rtl/matmul_feeder_if.sv
// Start request, operand matrices and array-side stream of the feeder.
interface matmul_feeder_if;
  import matmul_feeder_pkg::*;
  logic             start_i;
  logic [DIM_W-1:0] dim_n_i;
  logic [DIM_W-1:0] dim_k_i;
  logic [DIM_W-1:0] dim_m_i;
  logic [MAT_W-1:0] mat_a_i;
  logic [MAT_W-1:0] mat_b_i;
  logic [VEC_W-1:0] in_a_o;
  logic [VEC_W-1:0] in_b_o;
  logic             array_start_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start_i, dim_n_i, dim_k_i, dim_m_i, mat_a_i, mat_b_i,
    input  in_a_o, in_b_o, array_start_o, busy_o, done_o
  );
  modport slave (
    input  start_i, dim_n_i, dim_k_i, dim_m_i, mat_a_i, mat_b_i,
    output in_a_o, in_b_o, array_start_o, busy_o, done_o
  );
endinterface

// File: rtl/matmul_skew_lane.sv
// One row/column lane: picks element (t-IDX) of a K-long vector, or 0 outside
// the lane's active diagonal window or when the lane index is unused.
module matmul_skew_lane
  import matmul_feeder_pkg::*;
#(
  parameter int IDX = 0
) (
  input  logic [VEC_W-1:0] vec_i,
  input  logic [CNT_W-1:0] t_i,
  input  logic [DIM_W-1:0] limit_i,
  input  logic [DIM_W-1:0] klast_i,
  input  logic             en_i,
  output logic [DW-1:0]    elem_o
);
  localparam logic [CNT_W-1:0] IDX_C = CNT_W'(IDX);

  logic [CNT_W-1:0] off;

  always_comb begin
    off    = t_i - IDX_C;
    elem_o = '0;
    if (en_i && (DIM_W'(IDX) <= limit_i) && (t_i >= IDX_C) && (off <= CNT_W'(klast_i)))
      elem_o = vec_i[int'(off[DIM_W-1:0]) * DW +: DW];
  end
endmodule

// File: rtl/matmul_feeder.sv
// Latches A/B on start and streams them, diagonally skewed, into the
// systolic array; every output is registered from next-state values.
module matmul_feeder
  import matmul_feeder_pkg::*;
(
  input  logic           clk_i,
  input  logic           reset_i,
  matmul_feeder_if.slave bus
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] t_q, t_d;
  logic [MAT_W-1:0] a_q, a_d, b_q, b_d;
  logic [DIM_W-1:0] n_q, n_d, k_q, k_d, m_q, m_d;
  logic [VEC_W-1:0] in_a_q, in_b_q, a_nxt, b_nxt;
  logic             arr_q, busy_q, done_q;
  logic [CNT_W-1:0] t_last;
  logic             feed_d;

  // Last FEED index is T_F-1 = N+K+M-3, i.e. the sum of the minus-one dims.
  assign t_last = CNT_W'(n_q) + CNT_W'(k_q) + CNT_W'(m_q);
  assign feed_d = (state_d == FEED);

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    a_d     = a_q;
    b_d     = b_q;
    n_d     = n_q;
    k_d     = k_q;
    m_d     = m_q;
    unique case (state_q)
      IDLE: if (bus.start_i) begin
        a_d     = bus.mat_a_i;
        b_d     = bus.mat_b_i;
        n_d     = bus.dim_n_i;
        k_d     = bus.dim_k_i;
        m_d     = bus.dim_m_i;
        t_d     = '0;
        state_d = FEED;
      end
      FEED: if (t_q == t_last) begin
        t_d     = '0;
        state_d = DRAIN;
      end else begin
        t_d = t_q + 1'b1;
      end
      DRAIN: if (t_q == CNT_W'(PE_LAT - 1)) begin
        t_d     = '0;
        state_d = DONE;
      end else begin
        t_d = t_q + 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  for (genvar r = 0; r < MAX_DIM; r++) begin : g_row
    matmul_skew_lane #(.IDX(r)) u_lane (
      .vec_i   (a_d[r*VEC_W +: VEC_W]),
      .t_i     (t_d),
      .limit_i (n_d),
      .klast_i (k_d),
      .en_i    (feed_d),
      .elem_o  (a_nxt[r*DW +: DW])
    );
  end

  // Columns of B are strided in the row-major bus, so gather them first.
  for (genvar c = 0; c < MAX_DIM; c++) begin : g_col
    logic [VEC_W-1:0] bcol;
    for (genvar k = 0; k < MAX_DIM; k++) begin : g_k
      assign bcol[k*DW +: DW] = b_d[elem_idx(k, c)*DW +: DW];
    end
    matmul_skew_lane #(.IDX(c)) u_lane (
      .vec_i   (bcol),
      .t_i     (t_d),
      .limit_i (m_d),
      .klast_i (k_d),
      .en_i    (feed_d),
      .elem_o  (b_nxt[c*DW +: DW])
    );
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      t_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
      k_q     <= '0;
      m_q     <= '0;
      in_a_q  <= '0;
      in_b_q  <= '0;
      arr_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      a_q     <= a_d;
      b_q     <= b_d;
      n_q     <= n_d;
      k_q     <= k_d;
      m_q     <= m_d;
      in_a_q  <= a_nxt;
      in_b_q  <= b_nxt;
      arr_q   <= (state_d != IDLE);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  assign bus.in_a_o        = in_a_q;
  assign bus.in_b_o        = in_b_q;
  assign bus.array_start_o = arr_q;
  assign bus.busy_o        = busy_q;
  assign bus.done_o        = done_q;
endmodule

// File: tb/tb_matmul_feeder.sv
// Directed bench for matmul_feeder with a behavioural 4x4 systolic array.
module tb_matmul_feeder;
  logic clk_i = 1'b0;
  logic reset_i;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   exp_c [4][4];

  matmul_feeder_if bus ();
  matmul_feeder dut (.clk_i(clk_i), .reset_i(reset_i), .bus(bus));

  always #5 clk_i = ~clk_i;

  // Output-stationary array: A flows right, B flows down, PEs clear while disabled.
  logic [7:0]  pa  [4][4];
  logic [7:0]  pb  [4][4];
  logic [31:0] acc [4][4];
  always @(posedge clk_i) begin
    logic [7:0] ain, bin;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!bus.array_start_o) begin
          pa[r][c]  <= '0;
          pb[r][c]  <= '0;
          acc[r][c] <= '0;
        end else begin
          ain = (c == 0) ? bus.in_a_o[r*8 +: 8] : pa[r][(c > 0) ? c-1 : 0];
          bin = (r == 0) ? bus.in_b_o[c*8 +: 8] : pb[(r > 0) ? r-1 : 0][c];
          pa[r][c]  <= ain;
          pb[r][c]  <= bin;
          acc[r][c] <= acc[r][c] + 32'(ain) * 32'(bin);
        end
      end
    end
  end

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctl;   // {array_start, busy, done}
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [127:0] put(input logic [127:0] m, input int r, input int c,
                                       input logic [7:0] v);
    m[(r*4+c)*8 +: 8] = v;
    return m;
  endfunction

  function automatic logic [2:0] ctl();
    return {bus.array_start_o, bus.busy_o, bus.done_o};
  endfunction

  task automatic check_res(input string nm, input int n, input int m);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < m; c++)
        check($sformatf("%s C[%0d][%0d]", nm, r, c), 64'(acc[r][c]), 64'(exp_c[r][c]));
  endtask

  // Presents start for one cycle; returns at cycle 1 (first FEED cycle).
  task automatic start_run(input int n, input int k, input int m,
                           input logic [127:0] ma, input logic [127:0] mb);
    bus.dim_n_i = 2'(n - 1);
    bus.dim_k_i = 2'(k - 1);
    bus.dim_m_i = 2'(m - 1);
    bus.mat_a_i = ma;
    bus.mat_b_i = mb;
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
  endtask

  // From cycle 1, runs until done_o (bounded); reports done cycle and busy cycles.
  task automatic run_to_done(output int dcyc, output int bcnt);
    dcyc = 1;
    bcnt = 0;
    while (!bus.done_o && dcyc < 40) begin
      if (bus.busy_o) bcnt++;
      step();
      dcyc++;
    end
    if (bus.busy_o) bcnt++;
  endtask

  initial begin
    logic [127:0] ma, mb;
    int dcyc, bcnt, dones;
    logic leak;

    bus.start_i = 1'b0;
    bus.dim_n_i = '0;
    bus.dim_k_i = '0;
    bus.dim_m_i = '0;
    bus.mat_a_i = '0;
    bus.mat_b_i = '0;
    reset_i = 1'b1;
    step();
    step();
    check("reset in_a", 64'(bus.in_a_o), 64'd0);
    check("reset in_b", 64'(bus.in_b_o), 64'd0);
    check("reset ctl", 64'(ctl()), 64'd0);
    reset_i = 1'b0;
    step();

    // 2x2x2 streaming table
    vecs[0] = '{1, 32'h0000_0001, 32'h0000_0005, 3'b110};
    vecs[1] = '{2, 32'h0000_0302, 32'h0000_0607, 3'b110};
    vecs[2] = '{3, 32'h0000_0400, 32'h0000_0800, 3'b110};
    vecs[3] = '{4, 32'h0000_0000, 32'h0000_0000, 3'b110};
    vecs[4] = '{5, 32'h0000_0000, 32'h0000_0000, 3'b110};
    vecs[5] = '{6, 32'h0000_0000, 32'h0000_0000, 3'b111};
    vecs[6] = '{7, 32'h0000_0000, 32'h0000_0000, 3'b000};
    ma = '0; ma = put(ma, 0, 0, 8'd1); ma = put(ma, 0, 1, 8'd2);
    ma = put(ma, 1, 0, 8'd3); ma = put(ma, 1, 1, 8'd4);
    mb = '0; mb = put(mb, 0, 0, 8'd5); mb = put(mb, 0, 1, 8'd6);
    mb = put(mb, 1, 0, 8'd7); mb = put(mb, 1, 1, 8'd8);
    exp_c[0][0] = 19; exp_c[0][1] = 22; exp_c[1][0] = 43; exp_c[1][1] = 50;
    start_run(2, 2, 2, ma, mb);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("2x2 c%0d in_a", vecs[i].cyc), 64'(bus.in_a_o), 64'(vecs[i].a));
      check($sformatf("2x2 c%0d in_b", vecs[i].cyc), 64'(bus.in_b_o), 64'(vecs[i].b));
      check($sformatf("2x2 c%0d ctl", vecs[i].cyc), 64'(ctl()), 64'(vecs[i].ctl));
      if (vecs[i].cyc == 6) check_res("2x2", 2, 2);
      step();
    end

    // 1x1x1
    ma = put('0, 0, 0, 8'd9);
    mb = put('0, 0, 0, 8'd3);
    exp_c[0][0] = 27;
    start_run(1, 1, 1, ma, mb);
    check("1x1 in_a", 64'(bus.in_a_o), 64'd9);
    check("1x1 in_b", 64'(bus.in_b_o), 64'd3);
    run_to_done(dcyc, bcnt);
    check("1x1 done cycle", 64'(dcyc), 64'd3);
    check_res("1x1", 1, 1);
    step();
    step();

    // 4x4x4 identity times B
    ma = '0; mb = '0;
    for (int r = 0; r < 4; r++) begin
      ma = put(ma, r, r, 8'd1);
      for (int c = 0; c < 4; c++) begin
        mb = put(mb, r, c, 8'(r*4 + c + 1));
        exp_c[r][c] = r*4 + c + 1;
      end
    end
    start_run(4, 4, 4, ma, mb);
    run_to_done(dcyc, bcnt);
    check("4x4 done cycle", 64'(dcyc), 64'd12);
    check("4x4 busy cycles", 64'(bcnt), 64'd12);
    check_res("4x4", 4, 4);
    step();
    step();

    // start held high through a 3x2x3 run; A changed mid-FEED
    ma = '0; mb = '0;
    ma = put(ma, 0, 0, 8'd1); ma = put(ma, 0, 1, 8'd2);
    ma = put(ma, 1, 0, 8'd3); ma = put(ma, 1, 1, 8'd4);
    ma = put(ma, 2, 0, 8'd5); ma = put(ma, 2, 1, 8'd6);
    mb = put(mb, 0, 0, 8'd1); mb = put(mb, 0, 2, 8'd2);
    mb = put(mb, 1, 1, 8'd1); mb = put(mb, 1, 2, 8'd3);
    exp_c[0][0] = 1; exp_c[0][1] = 2; exp_c[0][2] = 8;
    exp_c[1][0] = 3; exp_c[1][1] = 4; exp_c[1][2] = 18;
    exp_c[2][0] = 5; exp_c[2][1] = 6; exp_c[2][2] = 28;
    bus.dim_n_i = 2'd2; bus.dim_k_i = 2'd1; bus.dim_m_i = 2'd2;
    bus.mat_a_i = ma; bus.mat_b_i = mb;
    bus.start_i = 1'b1;
    step();
    dones = 0;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      if (cyc == 2) bus.mat_a_i = {16{8'hEE}};
      if (bus.done_o) begin
        dones++;
        check("hold done cycle", 64'(cyc), 64'd8);
        check_res("3x2x3", 3, 3);
      end
      if (cyc == 9) check("hold idle gap busy", 64'(bus.busy_o), 64'd0);
      else step();
    end
    check("hold first-run dones", 64'(dones), 64'd1);
    step();
    check("hold restart busy", 64'(bus.busy_o), 64'd1);
    dones = 0;
    for (int cyc = 10; cyc <= 18; cyc++) begin
      if (bus.done_o) begin
        dones++;
        bus.start_i = 1'b0;
      end
      if (cyc < 18) step();
    end
    bus.start_i = 1'b0;
    check("hold second-run dones", 64'(dones), 64'd1);
    check("hold end busy", 64'(bus.busy_o), 64'd0);
    step();
    step();

    // N=2 K=3 M=1: unused rows/cols stay zero
    ma = '0; mb = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma = put(ma, r, c, 8'(r*4 + c + 1));
        mb = put(mb, r, c, 8'(r*4 + c + 17));
      end
    exp_c[0][0] = 134; exp_c[1][0] = 386;
    start_run(2, 3, 1, ma, mb);
    leak = 1'b0;
    dcyc = 1;
    bcnt = 0;
    while (!bus.done_o && dcyc < 40) begin
      if (bus.in_a_o[31:16] != 0 || bus.in_b_o[31:8] != 0) leak = 1'b1;
      if (bus.busy_o) bcnt++;
      step();
      dcyc++;
    end
    if (bus.busy_o) bcnt++;
    check("231 unused lanes zero", 64'(leak), 64'd0);
    check("231 done cycle", 64'(dcyc), 64'd6);
    check("231 busy cycles", 64'(bcnt), 64'd6);
    check_res("231", 2, 1);
    step();
    step();

    // reset pulsed at t=2 of a 4x4x4 run
    start_run(4, 4, 4, {16{8'h01}}, {16{8'h02}});
    step();
    step();
    #2 reset_i = 1'b1;
    #1;
    check("abort in_a", 64'(bus.in_a_o), 64'd0);
    check("abort in_b", 64'(bus.in_b_o), 64'd0);
    check("abort ctl", 64'(ctl()), 64'd0);
    #3 reset_i = 1'b0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus.done_o || bus.busy_o) dones++;
    end
    check("abort no activity", 64'(dones), 64'd0);
    ma = '0; mb = '0;
    for (int r = 0; r < 4; r++) begin
      ma = put(ma, r, r, 8'd1);
      for (int c = 0; c < 4; c++) begin
        mb = put(mb, r, c, 8'(r*4 + c + 1));
        exp_c[r][c] = r*4 + c + 1;
      end
    end
    start_run(4, 4, 4, ma, mb);
    run_to_done(dcyc, bcnt);
    check("post-reset done cycle", 64'(dcyc), 64'd12);
    check_res("post-reset", 4, 4);
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
